// File: rtl/sdr_ch3_arb.sv
// sdr_ch3_arb: registered arbiter/sequencer for SDRAM channel 3 (CLK_96M domain).
// Serves ROM loader, CPU and aux (hiscore/NVRAM) requesters one transaction at
// a time, issues a single-cycle ch3_req and routes completion back to the winner.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   download                     ROM download active (ROM-only eligibility)
//   {rom,cpu,aux}_req/addr/din/be/rnw   requester commands (level req)
//   {rom,cpu,aux}_rdy            one-cycle completion pulses
//   rd_data                      read data, held until next completion
//   ch3_addr/din/be/rnw, ch3_req registered command + issue pulse to sdram
//   ch3_ready, ch3_dout          completion from sdram
//   busy, grant, timeout_err     status (timeout_err sticky until reset)
module sdr_ch3_arb #(
    parameter int unsigned AUX_EVERY = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        download,
    input  logic        rom_req,
    input  logic        cpu_req,
    input  logic        aux_req,
    input  logic [24:1] rom_addr,
    input  logic [24:1] cpu_addr,
    input  logic [24:1] aux_addr,
    input  logic [15:0] rom_din,
    input  logic [15:0] cpu_din,
    input  logic [15:0] aux_din,
    input  logic [1:0]  rom_be,
    input  logic [1:0]  cpu_be,
    input  logic [1:0]  aux_be,
    input  logic        rom_rnw,
    input  logic        cpu_rnw,
    input  logic        aux_rnw,
    output logic        rom_rdy,
    output logic        cpu_rdy,
    output logic        aux_rdy,
    output logic [15:0] rd_data,
    output logic [24:1] ch3_addr,
    output logic [15:0] ch3_din,
    output logic [1:0]  ch3_be,
    output logic        ch3_rnw,
    output logic        ch3_req,
    input  logic        ch3_ready,
    input  logic [15:0] ch3_dout,
    output logic        busy,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned STV_W = 4;
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(AUX_EVERY);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_ROM  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_AUX  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [24:1]      ch3_addr_q;
    logic [15:0]      ch3_din_q;
    logic [1:0]       ch3_be_q;
    logic             ch3_rnw_q;
    logic             ch3_req_q;
    logic             rom_rdy_q, cpu_rdy_q, aux_rdy_q;
    logic [15:0]      rd_data_q;
    logic             busy_q;
    logic             timeout_err_q;
    logic             mask_q;
    logic [STV_W-1:0] starve_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic [1:0]       win_d;
    logic [24:1]      sel_addr_d;
    logic [15:0]      sel_din_d;
    logic [1:0]       sel_be_d;
    logic             sel_rnw_d;
    logic             fin_ok_d;
    logic             fin_to_d;

    // Winner selection. The IDLE cycle right after DONE is a settle cycle: the
    // just-served requester may still hold req, so nobody is granted in it.
    always_comb begin
        win_d = G_NONE;
        if (state_q == S_IDLE && !mask_q) begin
            if (download) begin
                if (rom_req) win_d = G_ROM;
            end else if (aux_req && (starve_q == STARVE_MAX || !cpu_req)) begin
                win_d = G_AUX;
            end else if (cpu_req) begin
                win_d = G_CPU;
            end
        end
    end

    // Command mux for the winner.
    always_comb begin
        sel_addr_d = cpu_addr;
        sel_din_d  = cpu_din;
        sel_be_d   = cpu_be;
        sel_rnw_d  = cpu_rnw;
        case (win_d)
            G_ROM: begin
                sel_addr_d = rom_addr;
                sel_din_d  = rom_din;
                sel_be_d   = rom_be;
                sel_rnw_d  = rom_rnw;
            end
            G_AUX: begin
                sel_addr_d = aux_addr;
                sel_din_d  = aux_din;
                sel_be_d   = aux_be;
                sel_rnw_d  = aux_rnw;
            end
            default: ;
        endcase
    end

    // Completion: ch3_ready is honoured in ISSUE or WAIT only; stale ones are dropped.
    always_comb begin
        fin_ok_d = (state_q == S_ISSUE || state_q == S_WAIT) && ch3_ready;
        fin_to_d = (state_q == S_WAIT) && !ch3_ready && (wait_cnt_q == TO_LAST);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= G_NONE;
            ch3_addr_q    <= '0;
            ch3_din_q     <= '0;
            ch3_be_q      <= '0;
            ch3_rnw_q     <= 1'b1;
            ch3_req_q     <= 1'b0;
            rom_rdy_q     <= 1'b0;
            cpu_rdy_q     <= 1'b0;
            aux_rdy_q     <= 1'b0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            mask_q        <= 1'b0;
            starve_q      <= '0;
            wait_cnt_q    <= '0;
        end else begin
            ch3_req_q <= 1'b0;
            rom_rdy_q <= 1'b0;
            cpu_rdy_q <= 1'b0;
            aux_rdy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mask_q <= 1'b0;
                    if (win_d == G_AUX || !aux_req) begin
                        starve_q <= '0;
                    end else if (win_d == G_CPU && starve_q != STARVE_MAX) begin
                        starve_q <= starve_q + 1'b1;
                    end
                    if (win_d != G_NONE) begin
                        state_q    <= S_ISSUE;
                        grant_q    <= win_d;
                        ch3_addr_q <= sel_addr_d;
                        ch3_din_q  <= sel_din_d;
                        ch3_be_q   <= sel_be_d;
                        ch3_rnw_q  <= sel_rnw_d;
                        ch3_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT:  wait_cnt_q <= wait_cnt_q + 1'b1;
                S_DONE: begin
                    state_q <= S_IDLE;
                    grant_q <= G_NONE;
                    busy_q  <= 1'b0;
                    mask_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
            if (fin_ok_d || fin_to_d) begin
                state_q   <= S_DONE;
                rom_rdy_q <= (grant_q == G_ROM);
                cpu_rdy_q <= (grant_q == G_CPU);
                aux_rdy_q <= (grant_q == G_AUX);
                if (ch3_rnw_q) rd_data_q <= fin_ok_d ? ch3_dout : 16'hFFFF;
                if (fin_to_d) timeout_err_q <= 1'b1;
            end
        end
    end

    assign grant       = grant_q;
    assign ch3_addr    = ch3_addr_q;
    assign ch3_din     = ch3_din_q;
    assign ch3_be      = ch3_be_q;
    assign ch3_rnw     = ch3_rnw_q;
    assign ch3_req     = ch3_req_q;
    assign rom_rdy     = rom_rdy_q;
    assign cpu_rdy     = cpu_rdy_q;
    assign aux_rdy     = aux_rdy_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdr_ch3_arb.sv
// Self-checking bench for sdr_ch3_arb: directed scenarios plus randomized
// single-requester transactions against a transaction-level reference model.
module tb_sdr_ch3_arb;

    localparam int unsigned AUX_EVERY = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        download = 1'b0;
    logic        rom_req = 1'b0, cpu_req = 1'b0, aux_req = 1'b0;
    logic [24:1] rom_addr = '0, cpu_addr = '0, aux_addr = '0;
    logic [15:0] rom_din = '0, cpu_din = '0, aux_din = '0;
    logic [1:0]  rom_be = '0, cpu_be = '0, aux_be = '0;
    logic        rom_rnw = 1'b1, cpu_rnw = 1'b1, aux_rnw = 1'b1;
    logic        rom_rdy, cpu_rdy, aux_rdy;
    logic [15:0] rd_data;
    logic [24:1] ch3_addr;
    logic [15:0] ch3_din;
    logic [1:0]  ch3_be;
    logic        ch3_rnw, ch3_req;
    logic        ch3_ready = 1'b0;
    logic [15:0] ch3_dout = '0;
    logic        busy;
    logic [1:0]  grant;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // sdram responder controls
    bit          resp_en = 1'b1;
    int          resp_lat = 2;
    logic [15:0] resp_data = '0;
    int          stale_req = 0;
    int          stale_done = 0;
    int          cd = -1;

    sdr_ch3_arb #(.AUX_EVERY(AUX_EVERY), .TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n), .download(download),
        .rom_req(rom_req), .cpu_req(cpu_req), .aux_req(aux_req),
        .rom_addr(rom_addr), .cpu_addr(cpu_addr), .aux_addr(aux_addr),
        .rom_din(rom_din), .cpu_din(cpu_din), .aux_din(aux_din),
        .rom_be(rom_be), .cpu_be(cpu_be), .aux_be(aux_be),
        .rom_rnw(rom_rnw), .cpu_rnw(cpu_rnw), .aux_rnw(aux_rnw),
        .rom_rdy(rom_rdy), .cpu_rdy(cpu_rdy), .aux_rdy(aux_rdy),
        .rd_data(rd_data),
        .ch3_addr(ch3_addr), .ch3_din(ch3_din), .ch3_be(ch3_be), .ch3_rnw(ch3_rnw),
        .ch3_req(ch3_req), .ch3_ready(ch3_ready), .ch3_dout(ch3_dout),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // sdram model: ready resp_lat cycles after the ch3_req cycle (0 = same cycle)
    always begin
        @(posedge clk);
        #1;
        ch3_ready = 1'b0;
        if (stale_req != stale_done) begin
            ch3_ready = 1'b1;
            ch3_dout  = 16'h1234;
            stale_done++;
        end
        if (ch3_req && resp_en) cd = resp_lat;
        if (cd == 0) begin
            ch3_ready = 1'b1;
            ch3_dout  = resp_data;
            cd = -1;
        end else if (cd > 0) begin
            cd--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [24:1] a, input logic [15:0] d,
                           input logic [1:0] b, input logic r);
        case (who)
            1: begin rom_addr = a; rom_din = d; rom_be = b; rom_rnw = r; rom_req = 1'b1; end
            2: begin cpu_addr = a; cpu_din = d; cpu_be = b; cpu_rnw = r; cpu_req = 1'b1; end
            3: begin aux_addr = a; aux_din = d; aux_be = b; aux_rnw = r; aux_req = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic clr_req(input int who);
        case (who)
            1: rom_req = 1'b0;
            2: cpu_req = 1'b0;
            3: aux_req = 1'b0;
            default: ;
        endcase
    endtask

    // Run until a *_rdy pulse (bounded). Reports who completed, issue count,
    // ticks to issue, cycles from ch3_req to rdy, and the issued command.
    task automatic serve(input int budget, input bit drop, output int who, output int iss,
                         output int t_iss, output int lat, output logic [24:1] a,
                         output logic [15:0] d, output logic [1:0] b, output logic r,
                         output logic [1:0] g);
        who = 0; iss = 0; t_iss = -1; lat = -1;
        a = '0; d = '0; b = '0; r = 1'b0; g = '0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ch3_req) begin
                iss++; t_iss = i; lat = 0;
                a = ch3_addr; d = ch3_din; b = ch3_be; r = ch3_rnw; g = grant;
            end else if (lat >= 0) begin
                lat++;
            end
            if (rom_rdy || cpu_rdy || aux_rdy) begin
                who = rom_rdy ? 1 : (cpu_rdy ? 2 : 3);
                if (drop) clr_req(who);
                break;
            end
        end
    endtask

    initial begin
        int who, iss, t_iss, lat, cpu_run, exp_who, n_iss, quiet, rwho, rlat;
        logic [24:1] a, ra;
        logic [15:0] d, rdin, rd_model;
        logic [1:0]  b, rbe, g;
        logic        r, rrnw;

        // reset values
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ctrl", 32'({ch3_req, rom_rdy, cpu_rdy, aux_rdy, busy, grant, timeout_err}), 32'(0));
        chk("rst_rnw", 32'(ch3_rnw), 32'(1));
        chk("rst_addr", 32'(ch3_addr), 32'(0));
        chk("rst_din_be", 32'({ch3_din, ch3_be}), 32'(0));
        chk("rst_rdata", 32'(rd_data), 32'(0));

        // CPU read, ready 4 cycles after ch3_req
        resp_lat = 4; resp_data = 16'hBEEF;
        set_req(2, 24'h000100, 16'h5A5A, 2'b11, 1'b1);
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("cpu_who", 32'(who), 32'(2));
        chk("cpu_t_issue", 32'(t_iss), 32'(1));
        chk("cpu_grant_issue", 32'(g), 32'(2));
        chk("cpu_addr", 32'(a), 32'h100);
        chk("cpu_rnw", 32'(r), 32'(1));
        chk("cpu_lat", 32'(lat), 32'(5));
        chk("cpu_issues", 32'(iss), 32'(1));
        chk("cpu_rdata", 32'(rd_data), 32'hBEEF);
        chk("cpu_grant_rdy", 32'(grant), 32'(2));
        tick();
        chk("cpu_grant_idle", 32'({grant, busy}), 32'(0));
        rd_model = 16'hBEEF;

        // requester dropping req one cycle late is not granted twice
        tick();
        resp_lat = 0; resp_data = 16'h1111;
        set_req(2, 24'h000200, 16'h0, 2'b01, 1'b1);
        serve(30, 1'b0, who, iss, t_iss, lat, a, d, b, r, g);
        chk("late_who", 32'(who), 32'(2));
        chk("late_lat", 32'(lat), 32'(1));
        chk("late_rdata", 32'(rd_data), 32'h1111);
        rd_model = 16'h1111;
        tick();
        clr_req(2);
        n_iss = 0;
        repeat (8) begin tick(); n_iss += int'(ch3_req); end
        chk("late_regrant", 32'(n_iss), 32'(0));

        // ROM not eligible with download=0
        set_req(1, 24'h0, 16'h0, 2'b00, 1'b0);
        quiet = 0;
        repeat (10) begin tick(); quiet += int'(ch3_req) + int'(busy); end
        chk("rom_noelig", 32'(quiet), 32'(0));

        // download=1: only ROM served while CPU held; writes pass verbatim
        resp_data = 16'h2222; resp_lat = 1;
        download = 1'b1;
        set_req(2, 24'h00ABCD, 16'hC0DE, 2'b10, 1'b0);
        for (int k = 0; k < 2; k++) begin
            ra = 24'($urandom); rdin = 16'($urandom); rbe = 2'($urandom);
            set_req(1, ra, rdin, rbe, 1'b0);
            serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
            chk("dl_who", 32'(who), 32'(1));
            chk("dl_addr", 32'(a), 32'(ra));
            chk("dl_din_be", 32'({d, b}), 32'({rdin, rbe}));
            chk("dl_rnw", 32'(r), 32'(0));
            chk("dl_rdata_hold", 32'(rd_data), 32'(rd_model));
            tick();
        end
        download = 1'b0;
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("dl_off_who", 32'(who), 32'(2));
        chk("dl_off_din_be", 32'({d, b}), 32'({16'hC0DE, 2'b10}));
        chk("cpu_wr_rdata_hold", 32'(rd_data), 32'(rd_model));

        // download rising during a CPU WAIT
        repeat (2) tick();
        resp_lat = 6; resp_data = 16'h3333;
        set_req(2, 24'h000300, 16'h0, 2'b11, 1'b1);
        tick();
        chk("dlr_issue", 32'({ch3_req, grant}), 32'({1'b1, 2'd2}));
        download = 1'b1;
        set_req(1, 24'h000400, 16'h4444, 2'b01, 1'b0);
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("dlr_cpu_done", 32'(who), 32'(2));
        chk("dlr_rdata", 32'(rd_data), 32'h3333);
        rd_model = 16'h3333;
        tick();
        set_req(2, 24'h000500, 16'h0, 2'b11, 1'b1);
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("dlr_rom_next", 32'(who), 32'(1));
        clr_req(2);

        // ROM write in flight when download falls
        repeat (2) tick();
        resp_lat = 3;
        set_req(1, 24'h000600, 16'h6666, 2'b11, 1'b0);
        tick();
        n_iss = int'(ch3_req);
        download = 1'b0;
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("romfall_who", 32'(who), 32'(1));
        n_iss += iss;
        repeat (8) begin tick(); n_iss += int'(ch3_req); end
        chk("romfall_issues", 32'(n_iss), 32'(1));

        // CPU and aux held: aux wins once after every AUX_EVERY CPU grants
        set_req(2, 24'h000700, 16'h0, 2'b11, 1'b1);
        set_req(3, 24'h000800, 16'h8888, 2'b11, 1'b0);
        cpu_run = 0;
        for (int k = 0; k < 18; k++) begin
            rlat = int'($urandom_range(0, 4));
            resp_lat = rlat;
            resp_data = 16'($urandom);
            serve(40, 1'b0, who, iss, t_iss, lat, a, d, b, r, g);
            exp_who = (cpu_run == int'(AUX_EVERY)) ? 3 : 2;
            chk("fair_who", 32'(who), 32'(exp_who));
            chk("fair_lat", 32'(lat), 32'(rlat + 1));
            if (exp_who == 2) rd_model = resp_data;
            chk("fair_rdata", 32'(rd_data), 32'(rd_model));
            cpu_run = (exp_who == 3) ? 0 : cpu_run + 1;
        end
        clr_req(2);
        clr_req(3);
        repeat (3) tick();

        // timeout: forced DONE 1023 WAIT cycles after ISSUE
        chk("to_err_pre", 32'(timeout_err), 32'(0));
        resp_en = 1'b0;
        set_req(2, 24'h000900, 16'h0, 2'b11, 1'b1);
        serve(1100, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("to_who", 32'(who), 32'(2));
        chk("to_lat", 32'(lat), 32'(1024));
        chk("to_rdata", 32'(rd_data), 32'hFFFF);
        chk("to_err", 32'(timeout_err), 32'(1));
        resp_en = 1'b1;
        repeat (2) tick();
        resp_lat = 2; resp_data = 16'h5555;
        set_req(2, 24'h000A00, 16'h0, 2'b11, 1'b1);
        serve(30, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
        chk("to_after_rdata", 32'(rd_data), 32'h5555);
        chk("to_err_sticky", 32'(timeout_err), 32'(1));

        // reset mid-WAIT, then stale ch3_ready
        repeat (2) tick();
        resp_en = 1'b0;
        set_req(2, 24'h000B00, 16'h0, 2'b11, 1'b1);
        repeat (4) tick();
        chk("rstw_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        tick();
        clr_req(2);
        reset_n = 1'b1;
        tick();
        stale_req++;
        quiet = 0;
        repeat (8) begin
            tick();
            quiet += int'(rom_rdy) + int'(cpu_rdy) + int'(aux_rdy) + int'(busy) + int'(ch3_req) + int'(grant != 2'd0);
        end
        chk("rstw_quiet", 32'(quiet), 32'(0));
        chk("rstw_err", 32'(timeout_err), 32'(0));
        chk("rstw_rdata", 32'(rd_data), 32'(0));
        chk("rstw_addr", 32'(ch3_addr), 32'(0));
        chk("rstw_din_be_rnw", 32'({ch3_din, ch3_be, ch3_rnw}), 32'(1));
        resp_en = 1'b1;
        rd_model = 16'h0;

        // randomized single-requester transactions
        for (int k = 0; k < 30; k++) begin
            repeat (2) tick();
            download = 1'($urandom);
            rwho = download ? 1 : int'($urandom_range(2, 3));
            ra = 24'($urandom); rdin = 16'($urandom); rbe = 2'($urandom); rrnw = 1'($urandom);
            rlat = int'($urandom_range(0, 6));
            resp_lat = rlat;
            resp_data = 16'($urandom);
            set_req(rwho, ra, rdin, rbe, rrnw);
            serve(40, 1'b1, who, iss, t_iss, lat, a, d, b, r, g);
            if (rrnw) rd_model = resp_data;
            chk("rnd_who", 32'(who), 32'(rwho));
            chk("rnd_grant", 32'(g), 32'(rwho));
            chk("rnd_addr", 32'(a), 32'(ra));
            chk("rnd_din_be_rnw", 32'({d, b, r}), 32'({rdin, rbe, rrnw}));
            chk("rnd_lat", 32'(lat), 32'(rlat + 1));
            chk("rnd_rdata", 32'(rd_data), 32'(rd_model));
        end
        download = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
